systimer: RTL and testbench
===========================

SYSTIMER -- requirements
Module: systimer

Interface
REQ-001 SHALL have clk, input, 1: system clock; all state changes on its rising edge.
REQ-002 SHALL have rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have systimer_axi_awaddr, input, `MemAddrBus: write address; only bits [3:2] decoded.
REQ-004 SHALL have systimer_axi_awvalid / systimer_axi_awready, input / output, 1 each: write-address handshake.
REQ-005 SHALL have systimer_axi_wdata, input, `MemBus; and systimer_axi_wstrb, input, 4: write data and byte strobes.
REQ-006 SHALL have systimer_axi_wvalid / systimer_axi_wready, input / output, 1 each: write-data handshake.
REQ-007 SHALL have systimer_axi_araddr, input, `MemAddrBus; systimer_axi_arvalid, input, 1; systimer_axi_arready, output, 1: read-address channel.
REQ-008 SHALL have systimer_axi_rdata, output, `MemBus; systimer_axi_rvalid, output, 1; systimer_axi_rready, input, 1: read-data channel.
REQ-009 SHALL have irq_o, output, 1: level compare-match interrupt.
REQ-010 SHALL have no B or PROT channels; a write is complete at the AW/W handshake.

Function
REQ-011 SHALL use this register map: 0x0 CTRL (bit0 EN, bit1 AUTOCLR, other bits read 0); 0x4 CNT; 0x8 CMP; 0xC STAT (bit0 MATCH, write-1-to-clear).
REQ-012 SHALL use a three-state responder FSM: IDLE, WACK, RRESP.
REQ-013 IDLE, awvalid&&wvalid: SHALL go to WACK and apply the register write on that edge; in WACK, awready=wready=1 for exactly one cycle, then return to IDLE.
REQ-014 IDLE, arvalid without a write request: SHALL capture araddr and register rdata, pulse arready for one cycle, and go to RRESP with rvalid=1.
REQ-015 RRESP: SHALL hold rvalid and rdata stable until rready=1, then go to IDLE on that edge.
REQ-016 Read and write requested in the same cycle: the write SHALL win; the read is served after it.
REQ-017 Only awvalid or only wvalid present: SHALL wait in IDLE with no ready asserted.
REQ-018 Writes SHALL update only the bytes whose wstrb bit is 1; wstrb=0 SHALL leave the register unchanged.
REQ-019 When EN=1, CNT SHALL increment by 1 every cycle, wrapping from 0xFFFF_FFFF to 0x0.
REQ-020 A software write to CNT SHALL take priority over the increment in the same cycle.
REQ-021 When EN=1 and CNT==CMP, MATCH SHALL be set on the next edge; if AUTOCLR=1, CNT SHALL load 0 on that same edge.
REQ-022 When a hardware MATCH set and a software W1C occur in the same cycle, the set SHALL win.
REQ-023 Read latency SHALL be exactly 2 cycles from the arvalid sample to rvalid=1, given rready held high.

Reset
REQ-024 On rst_n=0, SHALL immediately force CTRL=0, CNT=0, CMP=0xFFFF_FFFF, MATCH=0, FSM=IDLE, and all ready/valid outputs, rdata and irq_o to 0.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no partial register update.

Configuration
REQ-026 With SYSTIMER_IRQ_EN defined, irq_o SHALL equal MATCH & CTRL bit2 (IRQEN, read/write).
REQ-027 Without SYSTIMER_IRQ_EN, irq_o SHALL be tied to 0 and CTRL bit2 SHALL read 0 and ignore writes; all other behaviour is unchanged.

Structure
REQ-028 Register offsets, CTRL/STAT bit positions and the CMP reset value SHALL be defined as macros in the shared defines.v header.
REQ-029 The counter/compare datapath SHALL be one sub-module, systimer_cnt; the AXI responder FSM and register file stay in systimer.

Verification
REQ-030 Write CMP=0x10 then CTRL=0x1 -> MATCH=1 about 17 cycles after EN; read 0xC returns 0x1.
REQ-031 CNT=0xFFFF_FFFE, EN=1 -> two cycles later CNT=0x0 with no error.
REQ-032 AWVALID, WVALID and ARVALID asserted in the same cycle -> the write is acked first, and the subsequent read returns the newly written value.
REQ-033 Read with rready held low for 5 cycles -> rvalid and rdata stay stable; completes on the cycle rready rises.
REQ-034 Write 0xAABBCCDD to CMP with wstrb=0x2 -> CMP=0xFFFFCCFF.
REQ-035 Assert rst_n=0 during RRESP -> rvalid=0 immediately; CNT=0 and CMP=0xFFFF_FFFF after release.

Source files
------------

// File: rtl/systimer_pkg.sv
// systimer_pkg: register map, widths, FSM states and byte-merge helper for the system timer.
// SYSTIMER_IRQ_EN selects whether CTRL bit2 (IRQEN) is implemented.
package systimer_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CNT = 2'd1;
  localparam logic [1:0] REG_CMP = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AUTOCLR = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int STAT_MATCH = 0;
  localparam logic [DATA_W-1:0] CMP_RST = 32'hFFFF_FFFF;
`ifdef SYSTIMER_IRQ_EN
  localparam logic [DATA_W-1:0] CTRL_MASK = 32'h7;
`else
  localparam logic [DATA_W-1:0] CTRL_MASK = 32'h3;
`endif
  typedef enum logic [1:0] {IDLE, WACK, RRESP} state_t;
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 8; i++) r[8*i+:8] = strb[i] ? wd[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/systimer_if.sv
// systimer_if: AXI-lite style bus (AW, W, AR, R; no B) between a master and the timer.
interface systimer_if;
  import systimer_pkg::*;
  logic [ADDR_W-1:0] awaddr;
  logic awvalid, awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0] wstrb;
  logic wvalid, wready;
  logic [ADDR_W-1:0] araddr;
  logic arvalid, arready;
  logic [DATA_W-1:0] rdata;
  logic rvalid, rready;
  modport master(output awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
                 input awready, wready, arready, rdata, rvalid);
  modport slave(input awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
                output awready, wready, arready, rdata, rvalid);
endinterface

// File: rtl/systimer_cnt.sv
// systimer_cnt: free-running counter, compare register and sticky MATCH flag.
module systimer_cnt
  import systimer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic autoclr,
  input  logic cnt_we,
  input  logic cmp_we,
  input  logic match_clr,
  input  logic [DATA_W-1:0] cnt_wd,
  input  logic [DATA_W-1:0] cmp_wd,
  output logic [DATA_W-1:0] cnt,
  output logic [DATA_W-1:0] cmp,
  output logic match
);
  logic hit;
  assign hit = en && cnt == cmp;
  // Software writes beat both auto-clear and increment; a hardware set beats W1C.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      cmp <= CMP_RST;
      match <= 1'b0;
    end else begin
      cnt <= cnt_we ? cnt_wd : (hit && autoclr) ? '0 : cnt + {{(DATA_W-1){1'b0}}, en};
      cmp <= cmp_we ? cmp_wd : cmp;
      match <= hit || (match && !match_clr);
    end
endmodule

// File: rtl/systimer.sv
// systimer: bus responder FSM and CTRL register around systimer_cnt.
// Define SYSTIMER_IRQ_EN to implement CTRL.IRQEN and drive irq_o.
module systimer
  import systimer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  systimer_if.slave systimer_axi,
  output logic irq_o
);
  state_t state, state_n;
  logic [DATA_W-1:0] ctrl, cnt, cmp, rdata_q, rmux, cnt_wd, cmp_wd;
  logic [1:0] wsel, raddr;
  logic match, rvalid_q, wr, rd, rload, rdone, unused_addr;
  always_comb begin
    wsel = systimer_axi.awaddr[3:2];
    wr = state == IDLE && systimer_axi.awvalid && systimer_axi.wvalid;
    rd = state == IDLE && systimer_axi.arvalid && !wr;
    rload = state == RRESP && !rvalid_q;
    rdone = state == RRESP && rvalid_q && systimer_axi.rready;
    state_n = (state == WACK || rdone) ? IDLE : wr ? WACK : rd ? RRESP : state;
    rmux = raddr == REG_CTRL ? ctrl : raddr == REG_CNT ? cnt : raddr == REG_CMP ? cmp :
           {{(DATA_W-1){1'b0}}, match};
    cnt_wd = merge(cnt, systimer_axi.wdata, systimer_axi.wstrb);
    cmp_wd = merge(cmp, systimer_axi.wdata, systimer_axi.wstrb);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // First RRESP cycle acks the address and loads rdata, so rvalid rises two edges after arvalid.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      raddr <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      ctrl <= '0;
    end else begin
      if (rd) raddr <= systimer_axi.araddr[3:2];
      if (rload) rdata_q <= rmux;
      rvalid_q <= rload || (rvalid_q && !rdone);
      if (wr && wsel == REG_CTRL) ctrl <= merge(ctrl, systimer_axi.wdata, systimer_axi.wstrb) & CTRL_MASK;
    end
  assign systimer_axi.awready = state == WACK;
  assign systimer_axi.wready = state == WACK;
  assign systimer_axi.arready = rload;
  assign systimer_axi.rvalid = rvalid_q;
  assign systimer_axi.rdata = rdata_q;
  assign unused_addr = ^{systimer_axi.awaddr[ADDR_W-1:4], systimer_axi.awaddr[1:0],
                         systimer_axi.araddr[ADDR_W-1:4], systimer_axi.araddr[1:0]};
`ifdef SYSTIMER_IRQ_EN
  assign irq_o = match & ctrl[CTRL_IRQEN];
`else
  assign irq_o = 1'b0;
`endif
  systimer_cnt u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .en(ctrl[CTRL_EN]),
    .autoclr(ctrl[CTRL_AUTOCLR]),
    .cnt_we(wr && wsel == REG_CNT),
    .cmp_we(wr && wsel == REG_CMP),
    .match_clr(wr && wsel == REG_STAT && systimer_axi.wstrb[0] && systimer_axi.wdata[STAT_MATCH]),
    .cnt_wd(cnt_wd),
    .cmp_wd(cmp_wd),
    .cnt(cnt),
    .cmp(cmp),
    .match(match)
  );
endmodule

// File: tb/tb_systimer.sv
// tb_systimer: directed and random bus traffic checked against a cycle-level register model.
module tb_systimer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic irq;
  int vectors = 0;
  int errs = 0;
  logic [31:0] m_ctrl, m_cnt, m_cmp;
  logic m_match;
  logic p_we;
  logic [1:0] p_sel;
  logic [31:0] p_data;
  logic [3:0] p_strb;
`ifdef SYSTIMER_IRQ_EN
  localparam logic [31:0] MASK = 32'h7;
`else
  localparam logic [31:0] MASK = 32'h3;
`endif

  systimer_if systimer_axi();
  systimer dut (.clk(clk), .rst_n(rst_n), .systimer_axi(systimer_axi), .irq_o(irq));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] mread(input logic [1:0] sel);
    case (sel)
      2'd0: return m_ctrl;
      2'd1: return m_cnt;
      2'd2: return m_cmp;
      default: return {31'b0, m_match};
    endcase
  endfunction

  function automatic logic mirq();
`ifdef SYSTIMER_IRQ_EN
    return m_match & m_ctrl[2];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_ctrl = 0;
    m_cnt = 0;
    m_cmp = 32'hFFFF_FFFF;
    m_match = 0;
    p_we = 0;
  endtask

  // One clock edge: advance the model by the timer rules, then settle 1ns past the edge.
  task automatic tick();
    logic hit, n_match;
    logic [31:0] n_cnt;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      hit = m_ctrl[0] && m_cnt == m_cmp;
      n_cnt = m_ctrl[0] ? m_cnt + 1 : m_cnt;
      if (hit && m_ctrl[1]) n_cnt = 0;
      n_match = m_match;
      if (p_we)
        case (p_sel)
          2'd0: m_ctrl = bmerge(m_ctrl, p_data, p_strb) & MASK;
          2'd1: n_cnt = bmerge(m_cnt, p_data, p_strb);
          2'd2: m_cmp = bmerge(m_cmp, p_data, p_strb);
          default: if (p_strb[0] && p_data[0]) n_match = 0;
        endcase
      m_cnt = n_cnt;
      m_match = n_match | hit;
      p_we = 0;
    end
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = sel;
    systimer_axi.awaddr = a;
    systimer_axi.wdata = d;
    systimer_axi.wstrb = s;
    systimer_axi.awvalid = 1;
    systimer_axi.wvalid = 1;
    p_we = 1; p_sel = sel; p_data = d; p_strb = s;
    tick();
    chk("awready", systimer_axi.awready, 1);
    chk("wready", systimer_axi.wready, 1);
    tick();
    systimer_axi.awvalid = 0;
    systimer_axi.wvalid = 0;
    chk("wack_end", systimer_axi.awready, 0);
  endtask

  task automatic rd(input logic [1:0] sel, input int hold, output logic [31:0] got);
    logic [31:0] a, exp;
    a = $urandom;
    a[3:2] = sel;
    systimer_axi.araddr = a;
    systimer_axi.arvalid = 1;
    systimer_axi.rready = hold == 0;
    tick();
    chk("arready", systimer_axi.arready, 1);
    chk("rvalid_early", systimer_axi.rvalid, 0);
    exp = mread(sel);
    tick();
    systimer_axi.arvalid = 0;
    chk("rvalid", systimer_axi.rvalid, 1);
    chk("rdata", systimer_axi.rdata, exp);
    got = systimer_axi.rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rvalid_hold", systimer_axi.rvalid, 1);
      chk("rdata_hold", systimer_axi.rdata, exp);
    end
    systimer_axi.rready = 1;
    tick();
    chk("rvalid_done", systimer_axi.rvalid, 0);
    systimer_axi.rready = 0;
    chk("irq", irq, mirq());
  endtask

  initial begin
    logic [31:0] v, d;
    logic [1:0] sel;
    int n;
    systimer_axi.awaddr = 0; systimer_axi.awvalid = 0;
    systimer_axi.wdata = 0; systimer_axi.wstrb = 0; systimer_axi.wvalid = 0;
    systimer_axi.araddr = 0; systimer_axi.arvalid = 0; systimer_axi.rready = 0;
    model_reset();
    #1 rst_n = 0;
    #1;
    chk("rst_awready", systimer_axi.awready, 0);
    chk("rst_wready", systimer_axi.wready, 0);
    chk("rst_arready", systimer_axi.arready, 0);
    chk("rst_rvalid", systimer_axi.rvalid, 0);
    chk("rst_rdata", systimer_axi.rdata, 0);
    chk("rst_irq", irq, 0);
    tick();
    tick();
    rst_n = 1;
    rd(2'd0, 0, v); chk("rst_ctrl", v, 32'h0);
    rd(2'd1, 0, v); chk("rst_cnt", v, 32'h0);
    rd(2'd2, 0, v); chk("rst_cmp", v, 32'hFFFF_FFFF);
    rd(2'd3, 0, v); chk("rst_stat", v, 32'h0);
    wr(2'd2, 32'hAABB_CCDD, 4'h2);
    rd(2'd2, 0, v); chk("cmp_strb", v, 32'hFFFF_CCFF);
    wr(2'd2, 32'h1234_5678, 4'h0);
    rd(2'd2, 0, v); chk("cmp_strb0", v, 32'hFFFF_CCFF);
    // Compare-match timing: the STAT read sampling edge E+17 still sees 0, the next read sees 1.
    wr(2'd2, 32'h10, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    rd(2'd3, 0, v); chk("match_early", v, 0);
    repeat (11) tick();
    rd(2'd3, 0, v); chk("match_edge", v, 0);
    rd(2'd3, 0, v); chk("match_set", v, 1);
    wr(2'd3, 32'h1, 4'h1);
    rd(2'd3, 0, v); chk("match_w1c", v, 0);
    wr(2'd0, 32'h3, 4'hF);
    wr(2'd1, 32'h0, 4'hF);
    rd(2'd1, 2, v);
    n = 0;
    while (m_cnt != m_cmp && n < 40) begin tick(); n++; end
    chk("align_bound", n < 40, 1);
    wr(2'd3, 32'h1, 4'h1);
    rd(2'd3, 0, v); chk("set_beats_w1c", v, 1);
    repeat (7) tick();
    rd(2'd1, 0, v);
    wr(2'd0, 32'h0, 4'hF);
    wr(2'd1, 32'hFFFF_FFFE, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    rd(2'd1, 0, v); chk("cnt_wrap", v, 32'h0);
    wr(2'd0, 32'h7, 4'h1);
    rd(2'd0, 0, v); chk("ctrl_mask", v, MASK & 32'h7);
    // Write and read presented together: write first, then the read sees the new CMP.
    systimer_axi.awaddr = 32'h8; systimer_axi.wdata = 32'h0BAD_F00D; systimer_axi.wstrb = 4'hF;
    systimer_axi.awvalid = 1; systimer_axi.wvalid = 1;
    systimer_axi.araddr = 32'h8; systimer_axi.arvalid = 1; systimer_axi.rready = 1;
    p_we = 1; p_sel = 2'd2; p_data = 32'h0BAD_F00D; p_strb = 4'hF;
    tick();
    chk("both_awready", systimer_axi.awready, 1);
    chk("both_arready", systimer_axi.arready, 0);
    tick();
    systimer_axi.awvalid = 0; systimer_axi.wvalid = 0;
    tick();
    chk("both_arready2", systimer_axi.arready, 1);
    tick();
    systimer_axi.arvalid = 0;
    chk("both_rvalid", systimer_axi.rvalid, 1);
    chk("both_rdata", systimer_axi.rdata, 32'h0BAD_F00D);
    tick();
    chk("both_done", systimer_axi.rvalid, 0);
    systimer_axi.rready = 0;
    // Half a write request must never be acknowledged.
    systimer_axi.awaddr = 32'h8; systimer_axi.awvalid = 1;
    repeat (3) begin tick(); chk("aw_only", {systimer_axi.awready, systimer_axi.wready}, 0); end
    systimer_axi.awvalid = 0; systimer_axi.wvalid = 1;
    repeat (3) begin tick(); chk("w_only", {systimer_axi.awready, systimer_axi.wready}, 0); end
    systimer_axi.wvalid = 0;
    rd(2'd2, 0, v); chk("half_nowrite", v, 32'h0BAD_F00D);
    rd(2'd1, 5, v);
    for (int i = 0; i < 40; i++) begin
      sel = 2'($urandom);
      d = $urandom;
      if (sel != 2'd0 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 40);
      case ($urandom_range(0, 2))
        0: wr(sel, d, 4'($urandom));
        1: rd(sel, $urandom_range(0, 3), v);
        default: repeat ($urandom_range(1, 5)) tick();
      endcase
    end
    // Reset while a read response is pending.
    systimer_axi.araddr = 32'h4; systimer_axi.arvalid = 1; systimer_axi.rready = 0;
    tick();
    tick();
    systimer_axi.arvalid = 0;
    chk("pre_rst_rvalid", systimer_axi.rvalid, 1);
    rst_n = 0;
    #1;
    chk("rst_rresp_rvalid", systimer_axi.rvalid, 0);
    chk("rst_rresp_rdata", systimer_axi.rdata, 0);
    tick();
    rst_n = 1;
    rd(2'd1, 0, v); chk("post_rst_cnt", v, 32'h0);
    rd(2'd2, 0, v); chk("post_rst_cmp", v, 32'hFFFF_FFFF);
    // Reset while a write is being presented: nothing may land.
    systimer_axi.awaddr = 32'h8; systimer_axi.wdata = 32'h1234; systimer_axi.wstrb = 4'hF;
    systimer_axi.awvalid = 1; systimer_axi.wvalid = 1;
    #2 rst_n = 0;
    tick();
    systimer_axi.awvalid = 0; systimer_axi.wvalid = 0;
    rst_n = 1;
    rd(2'd2, 0, v); chk("rst_wr_cmp", v, 32'hFFFF_FFFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
